// File: rtl/coproc_result_buffer.sv
// coproc_result_buffer: in-order result FIFO released by a per-id commit/kill table.
// Define COPROC_RESULT_STATS_EN to add saturating sent/killed counters.
module coproc_result_buffer #(
  parameter int DEPTH  = 4,
  parameter int ID_W   = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pe_valid_i,
  input  logic [ID_W-1:0]   pe_id_i,
  input  logic [4:0]        pe_rd_i,
  input  logic [DATA_W-1:0] pe_data_i,
  output logic              pe_ready_o,
  output logic              drop_o,
  input  logic              commit_valid_i,
  input  logic [ID_W-1:0]   commit_id_i,
  input  logic              commit_kill_i,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic [ID_W-1:0]   result_id_o,
  output logic [4:0]        result_rd_o,
  output logic [DATA_W-1:0] result_data_o,
`ifdef COPROC_RESULT_STATS_EN
  output logic [15:0]       sent_cnt_o,
  output logic [15:0]       killed_cnt_o,
`endif
  output logic              result_we_o
);
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int NID = 2 ** ID_W;
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ID_W-1:0]   id_q [DEPTH];
  logic [ID_W-1:0]   id_d [DEPTH];
  logic [4:0]        rdst_q [DEPTH];
  logic [4:0]        rdst_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [NID-1:0]    seen_q, seen_d, kill_q, kill_d;
  logic              drop_q, drop_d;
  logic              empty, full, push, pop, head_seen, head_kill;
  logic [AW-1:0]     head;
  logic [ID_W-1:0]   head_id;
  always_comb begin
    empty     = wptr_q == rptr_q;
    full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    head      = rptr_q[AW-1:0];
    head_id   = id_q[head];
    head_seen = !empty && seen_q[head_id];
    head_kill = kill_q[head_id];
    push      = pe_valid_i && !full;
    pop       = head_seen && (head_kill || result_ready_i);
    drop_d    = pe_valid_i && full;
    wptr_d    = wptr_q + PW'(push);
    rptr_d    = rptr_q + PW'(pop);
    id_d      = id_q;
    rdst_d    = rdst_q;
    data_d    = data_q;
    seen_d    = seen_q;
    kill_d    = kill_q;
    if (push) begin
      id_d[wptr_q[AW-1:0]]   = pe_id_i;
      rdst_d[wptr_q[AW-1:0]] = pe_rd_i;
      data_d[wptr_q[AW-1:0]] = pe_data_i;
    end
    if (pop) begin
      seen_d[head_id] = 1'b0;
      kill_d[head_id] = 1'b0;
    end
    // A commit applied after the pop-clear lets a reused id be recorded in the same cycle
    if (commit_valid_i) begin
      seen_d[commit_id_i] = 1'b1;
      kill_d[commit_id_i] = commit_kill_i;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      id_q   <= '{default: '0};
      rdst_q <= '{default: '0};
      data_q <= '{default: '0};
      seen_q <= '0;
      kill_q <= '0;
      drop_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      id_q   <= id_d;
      rdst_q <= rdst_d;
      data_q <= data_d;
      seen_q <= seen_d;
      kill_q <= kill_d;
      drop_q <= drop_d;
    end
  end
  always_comb begin
    result_valid_o = head_seen && !head_kill;
    result_we_o    = result_valid_o;
    result_id_o    = result_valid_o ? head_id : '0;
    result_rd_o    = result_valid_o ? rdst_q[head] : '0;
    result_data_o  = result_valid_o ? data_q[head] : '0;
    pe_ready_o     = !full;
    drop_o         = drop_q;
  end
`ifdef COPROC_RESULT_STATS_EN
  logic [15:0] sent_cnt_q, sent_cnt_d, killed_cnt_q, killed_cnt_d;
  always_comb begin
    sent_cnt_d   = (result_valid_o && result_ready_i && sent_cnt_q != 16'hFFFF) ? sent_cnt_q + 16'd1 : sent_cnt_q;
    killed_cnt_d = (head_seen && head_kill && killed_cnt_q != 16'hFFFF) ? killed_cnt_q + 16'd1 : killed_cnt_q;
    sent_cnt_o   = sent_cnt_q;
    killed_cnt_o = killed_cnt_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sent_cnt_q   <= '0;
      killed_cnt_q <= '0;
    end else begin
      sent_cnt_q   <= sent_cnt_d;
      killed_cnt_q <= killed_cnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_coproc_result_buffer.sv
// tb_coproc_result_buffer: scenario tasks plus a scoreboard that checks every accepted result in order.
module tb_coproc_result_buffer;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        pe_valid_i, commit_valid_i, commit_kill_i, result_ready_i;
  logic [3:0]  pe_id_i, commit_id_i, result_id_o;
  logic [4:0]  pe_rd_i, result_rd_o;
  logic [31:0] pe_data_i, result_data_o;
  logic        pe_ready_o, drop_o, result_valid_o, result_we_o;
`ifdef COPROC_RESULT_STATS_EN
  logic [15:0] sent_cnt_o, killed_cnt_o;
`endif
  typedef struct packed {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;
  res_t exp_q[$];
  int total = 0;
  int bad = 0;
  int acc_cnt = 0;

  coproc_result_buffer dut (
    .clk_i(clk), .rst_i(rst_i),
    .pe_valid_i(pe_valid_i), .pe_id_i(pe_id_i), .pe_rd_i(pe_rd_i), .pe_data_i(pe_data_i),
    .pe_ready_o(pe_ready_o), .drop_o(drop_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_rd_o(result_rd_o), .result_data_o(result_data_o),
`ifdef COPROC_RESULT_STATS_EN
    .sent_cnt_o(sent_cnt_o), .killed_cnt_o(killed_cnt_o),
`endif
    .result_we_o(result_we_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    res_t got, want;
    if (!rst_i && result_valid_o && result_ready_i) begin
      got = {result_id_o, result_rd_o, result_data_o};
      acc_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result got=%h want=none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want || result_we_o !== 1'b1) begin
          bad++;
          $display("FAIL result_fields got=%h we=%b want=%h we=1", got, result_we_o, want);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] d, input bit exp);
    pe_valid_i = 1'b1;
    pe_id_i = id;
    pe_rd_i = rd;
    pe_data_i = d;
    if (exp) exp_q.push_back({id, rd, d});
    tick;
    pe_valid_i = 1'b0;
  endtask

  task automatic commit(input logic [3:0] id, input logic k);
    commit_valid_i = 1'b1;
    commit_id_i = id;
    commit_kill_i = k;
    tick;
    commit_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) tick;
    total++;
    if ({result_valid_o, pe_ready_o, drop_o, result_we_o} !== 4'b0100 || result_id_o !== 4'd0 || result_data_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_state got v/rdy/drop/we=%b%b%b%b id=%h data=%h want 0100 id=0 data=0",
               result_valid_o, pe_ready_o, drop_o, result_we_o, result_id_o, result_data_o);
    end
    rst_i = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    int a0 = acc_cnt;
    result_ready_i = 1'b1;
    push(4'd3, 5'd5, 32'hA5A5, 1'b1);
    total++;
    if (result_valid_o !== 1'b0) begin bad++; $display("FAIL basic_uncommitted got valid=%b want 0", result_valid_o); end
    commit(4'd3, 1'b0);
    total++;
    if (result_valid_o !== 1'b1 || result_id_o !== 4'd3 || result_rd_o !== 5'd5 || result_data_o !== 32'hA5A5 || result_we_o !== 1'b1) begin
      bad++;
      $display("FAIL basic_offer got v=%b id=%h rd=%0d data=%h we=%b want v=1 id=3 rd=5 data=a5a5 we=1",
               result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o);
    end
    repeat (4) tick;
    total++;
    if (acc_cnt - a0 !== 1) begin bad++; $display("FAIL basic_count got=%0d want=1", acc_cnt - a0); end
  endtask

  task automatic test_early_commit;
    int a0 = acc_cnt;
    commit(4'd2, 1'b0);
    repeat (2) tick;
    push(4'd2, 5'd9, 32'h1234_5678, 1'b1);
    total++;
    if (result_valid_o !== 1'b1 || result_id_o !== 4'd2) begin
      bad++;
      $display("FAIL early_commit got v=%b id=%h want v=1 id=2", result_valid_o, result_id_o);
    end
    repeat (3) tick;
    total++;
    if (acc_cnt - a0 !== 1) begin bad++; $display("FAIL early_count got=%0d want=1", acc_cnt - a0); end
  endtask

  task automatic test_kill;
    int a0 = acc_cnt;
`ifdef COPROC_RESULT_STATS_EN
    logic [15:0] k0 = killed_cnt_o;
`endif
    push(4'd1, 5'd1, 32'hDEAD, 1'b0);
    push(4'd2, 5'd2, 32'hBEEF, 1'b1);
    commit(4'd1, 1'b1);
    total++;
    if (result_valid_o !== 1'b0) begin bad++; $display("FAIL kill_head_hidden got valid=%b want 0", result_valid_o); end
    commit(4'd2, 1'b0);
    repeat (4) tick;
    total++;
    if (acc_cnt - a0 !== 1) begin bad++; $display("FAIL kill_count got=%0d want=1", acc_cnt - a0); end
`ifdef COPROC_RESULT_STATS_EN
    total++;
    if (killed_cnt_o - k0 !== 16'd1) begin bad++; $display("FAIL killed_cnt got=%0d want=1", killed_cnt_o - k0); end
`endif
  endtask

  task automatic test_full;
    int a0 = acc_cnt;
    result_ready_i = 1'b1;
    for (int i = 4; i < 8; i++) push(4'(i), 5'(i), 32'h100 + i, 1'b1);
    total++;
    if (pe_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want 0", pe_ready_o); end
    push(4'd8, 5'd8, 32'hBAD, 1'b0);
    total++;
    if (drop_o !== 1'b1) begin bad++; $display("FAIL drop_pulse got=%b want 1", drop_o); end
    tick;
    total++;
    if (drop_o !== 1'b0 || pe_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL drop_once got drop=%b rdy=%b want drop=0 rdy=0", drop_o, pe_ready_o);
    end
    for (int i = 4; i < 8; i++) commit(4'(i), 1'b0);
    repeat (4) tick;
    total++;
    if (acc_cnt - a0 !== 4 || pe_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL full_drain got=%0d rdy=%b want=4 rdy=1", acc_cnt - a0, pe_ready_o);
    end
  endtask

  task automatic test_hold;
    int a0 = acc_cnt;
    logic [31:0] d = $urandom;
    result_ready_i = 1'b0;
    push(4'd9, 5'd7, d, 1'b1);
    commit(4'd9, 1'b0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (result_valid_o !== 1'b1 || result_id_o !== 4'd9 || result_rd_o !== 5'd7 || result_data_o !== d) begin
        bad++;
        $display("FAIL hold_stable cycle=%0d got v=%b id=%h rd=%0d data=%h want v=1 id=9 rd=7 data=%h",
                 i, result_valid_o, result_id_o, result_rd_o, result_data_o, d);
      end
      tick;
    end
    result_ready_i = 1'b1;
    tick;
    total++;
    if (result_valid_o !== 1'b0 || acc_cnt - a0 !== 1) begin
      bad++;
      $display("FAIL hold_accept got v=%b n=%0d want v=0 n=1", result_valid_o, acc_cnt - a0);
    end
  endtask

  task automatic test_back_to_back;
    int a0 = acc_cnt;
    result_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      pe_valid_i = 1'b1;
      pe_id_i = 4'((i + 8) % 16);
      pe_rd_i = 5'($urandom);
      pe_data_i = $urandom;
      commit_valid_i = 1'b1;
      commit_id_i = pe_id_i;
      commit_kill_i = 1'b0;
      exp_q.push_back({pe_id_i, pe_rd_i, pe_data_i});
      if (i >= 8) result_ready_i = 1'($urandom_range(0, 1));
      tick;
    end
    pe_valid_i = 1'b0;
    commit_valid_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      result_ready_i = 1'($urandom_range(0, 1));
      tick;
    end
    result_ready_i = 1'b1;
    repeat (6) tick;
    total++;
    if (acc_cnt - a0 !== 12 || pe_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_count got=%0d rdy=%b want=12 rdy=1", acc_cnt - a0, pe_ready_o);
    end
  endtask

  task automatic test_reset_mid;
    int a0;
    result_ready_i = 1'b0;
    for (int i = 1; i < 4; i++) push(4'(i), 5'(i), 32'h300 + i, 1'b0);
    for (int i = 1; i < 4; i++) commit(4'(i), 1'b0);
    total++;
    if (result_valid_o !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b want 1", result_valid_o); end
    rst_i = 1'b1;
    tick;
    total++;
    if (result_valid_o !== 1'b0 || pe_ready_o !== 1'b1 || drop_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got v=%b rdy=%b drop=%b want v=0 rdy=1 drop=0", result_valid_o, pe_ready_o, drop_o);
    end
    rst_i = 1'b0;
    tick;
    a0 = acc_cnt;
    push(4'd1, 5'd4, 32'h4444, 1'b1);
    repeat (3) tick;
    total++;
    if (result_valid_o !== 1'b0) begin bad++; $display("FAIL mid_table_cleared got valid=%b want 0", result_valid_o); end
    result_ready_i = 1'b1;
    commit(4'd1, 1'b0);
    repeat (3) tick;
    total++;
    if (acc_cnt - a0 !== 1) begin bad++; $display("FAIL mid_after_count got=%0d want=1", acc_cnt - a0); end
`ifdef COPROC_RESULT_STATS_EN
    total++;
    if (sent_cnt_o !== 16'd1 || killed_cnt_o !== 16'd0) begin
      bad++;
      $display("FAIL stats_after_reset got sent=%0d killed=%0d want 1 0", sent_cnt_o, killed_cnt_o);
    end
`endif
  endtask

  initial begin
    pe_valid_i = 1'b0;
    pe_id_i = '0;
    pe_rd_i = '0;
    pe_data_i = '0;
    commit_valid_i = 1'b0;
    commit_id_i = '0;
    commit_kill_i = 1'b0;
    result_ready_i = 1'b0;
    test_reset;
    test_basic;
    test_early_commit;
    test_kill;
    test_full;
    test_hold;
    test_back_to_back;
    test_reset_mid;
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL leftover_expected got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
